core_wb_arbiter: RTL and testbench
==================================

# core_wb_arbiter

Write-back arbiter and load scoreboard for the rv32 core's integer register file. It merges two write sources onto the register file's single write port (wreg/rd_addr/rd_data): the single-cycle ALU result and out-of-order load returns from the LSU. It tracks destination registers of outstanding loads and drives a decode-stage stall for RAW/WAW hazards against them and against a buffered ALU write.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural registers; x0 is never written and never pending
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU write-back request
- alu_ready  out  1  ALU request accepted this cycle
- alu_rd_addr  in  5  ALU destination
- alu_rd_data  in  XLEN  ALU result
- lsu_valid  in  1  load return; always accepted, no ready
- lsu_rd_addr  in  5  load destination
- lsu_rd_data  in  XLEN  load data
- ld_issue  in  1  load issued this cycle, one-cycle pulse
- ld_issue_rd  in  5  destination of the issued load
- dec_rs1_addr, dec_rs2_addr, dec_rd_addr  in  5 each  decode operands
- dec_stall  out  1  decode must hold
- wreg  out  1  register-file write enable
- rd_addr  out  5  write address
- rd_data  out  XLEN  write data
- busy  out  1  a load is pending or the skid entry is valid (used by fence/debug halt)

## Operation
- State: pending[31:1] bits and a one-entry ALU skid register (skid_valid, skid_rd, skid_data).
- Write-port priority: LSU first, then skid, then ALU direct.
  - lsu_valid: write LSU. If an ALU request is also accepted, it goes into skid.
  - Else skid_valid: write skid and clear skid_valid.
  - Else alu_valid && alu_ready: write ALU directly.
- alu_ready = !skid_valid. The ALU stalls one cycle after every collision.
- wreg is forced 0 when the selected rd_addr == 0. rd_addr and rd_data are 0 when wreg is 0.
- Scoreboard:
  - ld_issue with ld_issue_rd != 0 sets pending[rd].
  - lsu_valid clears pending[lsu_rd_addr].
  - Same-cycle set and clear of the same register: set wins, and the bit ends at 1.
- dec_stall = any nonzero operand among rs1/rs2/rd with pending[x], or skid_valid && skid_rd equals a nonzero rs1/rs2/rd.
- The upstream pipeline guarantees no ld_issue to a pending rd; dec_stall enforces this. Behaviour on a violation is undefined, and the bench asserts it never happens.
- lsu_valid to a non-pending rd is legal; the write proceeds and the clear is a no-op.

## Timing
- All write-port outputs are combinational from the current state and inputs: zero-cycle latency from an accepted request to wreg.
- Register-file write lands at the next clk edge. The skid write lands one cycle after the collision.
- pending and skid update on posedge clk. dec_stall reflects the state as of that edge plus combinational inputs. A load issued in cycle N stalls dependents from cycle N+1.
- Reset (rstn low, any time):
  - Values: pending = 0, skid_valid = 0.
  - Outputs: wreg = 0, alu_ready = 1, dec_stall = 0, busy = 0.
  - An in-flight skid write is discarded.
  - Release is synchronized externally.

## Structure
- Shared core package: XLEN, NREG, and the REG_X0 = 5'd0 constant.
- Optional sub-module core_scoreboard: the pending vector, set/clear logic and the three-port hazard compare. The arbiter and skid logic stay in the top module.

## Test plan
- ALU only: alu_valid with rd=5, data=0x1234 for 3 cycles -> wreg=1, rd_addr=5 each cycle; alu_ready stays 1.
- Collision: lsu_valid rd=7 data=0xAA and alu_valid rd=8 data=0xBB in cycle N -> cycle N writes x7=0xAA; cycle N+1 writes x8=0xBB with alu_ready=0; cycle N+2 alu_ready=1.
- Load hazard: ld_issue rd=3 in cycle N; decode rs1=3 -> dec_stall=1 from N+1 until the cycle after lsu_valid rd=3. busy tracks the same window.
- Set/clear race: pending[4]=1; lsu_valid rd=4 with ld_issue rd=4 in the same cycle -> pending[4] stays 1 and dec_stall persists for rs2=4.
- x0: alu_valid rd=0 -> wreg=0. ld_issue rd=0 -> no pending bit set. Decode rs1=0 never stalls.
- Reset mid-collision: rstn low while skid_valid=1 -> after release wreg=0, alu_ready=1, busy=0, and no stale write occurs.

Source files
------------

// File: rtl/core_wb_arbiter_pkg.sv
// Shared core definitions for the integer write-back path.
//   XLEN   : integer data width
//   NREG   : number of architectural registers (x0 hard-wired to zero)
//   REG_W  : register address width
//   REG_X0 : address of the zero register
//   wb_src_e : which source currently owns the register-file write port
//   reg_hit  : nonzero address equality, used by every hazard compare
package core_wb_arbiter_pkg;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int REG_W = 5;

  localparam logic [REG_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LSU,
    SRC_SKID,
    SRC_ALU
  } wb_src_e;

  // x0 never participates in a dependency, so a zero operand never matches.
  function automatic logic reg_hit(input logic [REG_W-1:0] a,
                                   input logic [REG_W-1:0] b);
    return (a != REG_X0) && (a == b);
  endfunction

endpackage

// File: rtl/core_wb_arbiter_scoreboard.sv
// Load scoreboard: one pending bit per architectural register, set when a
// load issues and cleared when its data returns, plus the decode hazard
// compare against the three decode operands.
//   clk, rstn        : clock, asynchronous active-low reset
//   set_en, set_rd   : load issued this cycle and its destination
//   clr_en, clr_rd   : load returned this cycle and its destination
//   rs1, rs2, rd     : decode-stage operands
//   hazard           : some nonzero operand names a pending register
//   any_pending      : at least one load outstanding
module core_wb_arbiter_scoreboard
  import core_wb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_rd,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  output logic             hazard,
  output logic             any_pending
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  function automatic logic pend_hit(input logic [NREG-1:0] vec,
                                    input logic [REG_W-1:0] a);
    return (a != REG_X0) && vec[a];
  endfunction

  // Clear is applied before set so a same-cycle set/clear of one register
  // leaves it pending: the newly issued load still owes a write.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_rd] = 1'b0;
    if (set_en && (set_rd != REG_X0)) pending_nxt[set_rd] = 1'b1;
    pending_nxt[REG_X0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pending <= '0;
    else       pending <= pending_nxt;
  end

  assign hazard      = pend_hit(pending, rs1) | pend_hit(pending, rs2) |
                       pend_hit(pending, rd);
  assign any_pending = |pending;

endmodule

// File: rtl/core_wb_arbiter.sv
// Write-back arbiter for the integer register file. Merges ALU results and
// out-of-order load returns onto the single write port, buffering a colliding
// ALU result in a one-entry skid register, and raises the decode stall for
// hazards against outstanding loads or the buffered ALU write.
//   clk, rstn                         : clock, asynchronous active-low reset
//   alu_valid/alu_ready/alu_rd_*      : ALU write-back request and handshake
//   lsu_valid/lsu_rd_*                : load return, always accepted
//   ld_issue/ld_issue_rd              : load issue pulse and destination
//   dec_rs1_addr/dec_rs2_addr/dec_rd_addr : decode operands
//   dec_stall                         : decode must hold
//   wreg/rd_addr/rd_data              : register-file write port
//   busy                              : load pending or skid occupied
module core_wb_arbiter
  import core_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_W-1:0]  alu_rd_addr,
  input  logic [DATA_W-1:0] alu_rd_data,
  input  logic              lsu_valid,
  input  logic [REG_W-1:0]  lsu_rd_addr,
  input  logic [DATA_W-1:0] lsu_rd_data,
  input  logic              ld_issue,
  input  logic [REG_W-1:0]  ld_issue_rd,
  input  logic [REG_W-1:0]  dec_rs1_addr,
  input  logic [REG_W-1:0]  dec_rs2_addr,
  input  logic [REG_W-1:0]  dec_rd_addr,
  output logic              dec_stall,
  output logic              wreg,
  output logic [REG_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy
);

  logic              skid_valid;
  logic [REG_W-1:0]  skid_rd;
  logic [DATA_W-1:0] skid_data;

  logic              alu_acc;
  logic              collide;
  wb_src_e           src;
  logic [REG_W-1:0]  sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              sb_hazard;
  logic              sb_pending;
  logic              skid_hazard;

  // An occupied skid blocks the ALU, so the ALU loses one cycle per collision.
  assign alu_ready = !skid_valid;
  assign alu_acc   = alu_valid && alu_ready;
  assign collide   = lsu_valid && alu_acc;

  always_comb begin
    src = SRC_NONE;
    if (lsu_valid)       src = SRC_LSU;
    else if (skid_valid) src = SRC_SKID;
    else if (alu_acc)    src = SRC_ALU;
  end

  always_comb begin
    sel_rd   = REG_X0;
    sel_data = '0;
    unique case (src)
      SRC_LSU:  begin sel_rd = lsu_rd_addr; sel_data = lsu_rd_data; end
      SRC_SKID: begin sel_rd = skid_rd;     sel_data = skid_data;   end
      SRC_ALU:  begin sel_rd = alu_rd_addr; sel_data = alu_rd_data; end
      SRC_NONE: begin sel_rd = REG_X0;      sel_data = '0;          end
    endcase
  end

  // Writes to x0 are dropped, and the address/data buses are held at zero
  // whenever nothing is written.
  assign wreg    = (src != SRC_NONE) && (sel_rd != REG_X0);
  assign rd_addr = wreg ? sel_rd   : REG_X0;
  assign rd_data = wreg ? sel_data : '0;

  // Skid occupancy: filled on collision, drained on the first cycle without
  // a load return. Reset discards any buffered write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           skid_valid <= 1'b0;
    else if (collide)    skid_valid <= 1'b1;
    else if (!lsu_valid) skid_valid <= 1'b0;
  end

  // Skid payload is only meaningful while skid_valid is set.
  always_ff @(posedge clk) begin
    if (collide) begin
      skid_rd   <= alu_rd_addr;
      skid_data <= alu_rd_data;
    end
  end

  core_wb_arbiter_scoreboard u_sb (
    .clk         (clk),
    .rstn        (rstn),
    .set_en      (ld_issue),
    .set_rd      (ld_issue_rd),
    .clr_en      (lsu_valid),
    .clr_rd      (lsu_rd_addr),
    .rs1         (dec_rs1_addr),
    .rs2         (dec_rs2_addr),
    .rd          (dec_rd_addr),
    .hazard      (sb_hazard),
    .any_pending (sb_pending)
  );

  assign skid_hazard = skid_valid && (reg_hit(dec_rs1_addr, skid_rd) ||
                                      reg_hit(dec_rs2_addr, skid_rd) ||
                                      reg_hit(dec_rd_addr,  skid_rd));

  assign dec_stall = sb_hazard || skid_hazard;
  assign busy      = sb_pending || skid_valid;

endmodule

// File: tb/tb_core_wb_arbiter.sv
module tb_core_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd_addr;
  logic [31:0] alu_rd_data;
  logic        lsu_valid;
  logic [4:0]  lsu_rd_addr;
  logic [31:0] lsu_rd_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic [4:0]  dec_rs1_addr;
  logic [4:0]  dec_rs2_addr;
  logic [4:0]  dec_rd_addr;
  logic        dec_stall;
  logic        wreg;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  core_wb_arbiter dut (
    .clk          (clk),
    .rstn         (rstn),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd_addr  (alu_rd_addr),
    .alu_rd_data  (alu_rd_data),
    .lsu_valid    (lsu_valid),
    .lsu_rd_addr  (lsu_rd_addr),
    .lsu_rd_data  (lsu_rd_data),
    .ld_issue     (ld_issue),
    .ld_issue_rd  (ld_issue_rd),
    .dec_rs1_addr (dec_rs1_addr),
    .dec_rs2_addr (dec_rs2_addr),
    .dec_rd_addr  (dec_rd_addr),
    .dec_stall    (dec_stall),
    .wreg         (wreg),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy)
  );

  // Stimulus legality: a load may only target a pending register when that
  // register's return lands in the same cycle.
  logic [31:0] tb_pending;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) tb_pending <= '0;
    else begin
      if (ld_issue && ld_issue_rd != 0 && tb_pending[ld_issue_rd] &&
          !(lsu_valid && lsu_rd_addr == ld_issue_rd))
        $error("illegal ld_issue to pending x%0d", ld_issue_rd);
      if (lsu_valid) tb_pending[lsu_rd_addr] <= 1'b0;
      if (ld_issue && ld_issue_rd != 0) tb_pending[ld_issue_rd] <= 1'b1;
    end
  end

  task automatic idle();
    alu_valid = 0; alu_rd_addr = 0; alu_rd_data = 0;
    lsu_valid = 0; lsu_rd_addr = 0; lsu_rd_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    dec_rs1_addr = 0; dec_rs2_addr = 0; dec_rd_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 0;
    idle();
    #12;
    n_cmp++;
    if (wreg !== 1'b0 || alu_ready !== 1'b1 || dec_stall !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wreg=%b rdy=%b stall=%b busy=%b, want 0 1 0 0",
               wreg, alu_ready, dec_stall, busy);
    end
    @(negedge clk);
    rstn = 1;
    tick();
  endtask

  task automatic test_alu_only();
    for (int i = 0; i < 3; i++) begin
      idle();
      alu_valid = 1; alu_rd_addr = 5; alu_rd_data = 32'h1234;
      #1;
      n_cmp++;
      if (wreg !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'h1234 || alu_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL alu_only[%0d]: got wreg=%b addr=%0d data=%h rdy=%b, want 1 5 00001234 1",
                 i, wreg, rd_addr, rd_data, alu_ready);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_collision();
    // Cycle N: both sources; LSU wins the port.
    idle();
    lsu_valid = 1; lsu_rd_addr = 7; lsu_rd_data = 32'hAA;
    alu_valid = 1; alu_rd_addr = 8; alu_rd_data = 32'hBB;
    #1;
    n_cmp++;
    if (wreg !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'hAA || alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_n: got wreg=%b addr=%0d data=%h rdy=%b, want 1 7 000000aa 1",
               wreg, rd_addr, rd_data, alu_ready);
    end
    tick();
    // Cycle N+1: skid drains, a new ALU request is held off.
    idle();
    alu_valid = 1; alu_rd_addr = 9; alu_rd_data = 32'hCC;
    dec_rd_addr = 8;
    #1;
    n_cmp++;
    if (wreg !== 1'b1 || rd_addr !== 5'd8 || rd_data !== 32'hBB || alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_n1: got wreg=%b addr=%0d data=%h rdy=%b, want 1 8 000000bb 0",
               wreg, rd_addr, rd_data, alu_ready);
    end
    n_cmp++;
    if (dec_stall !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL skid_hazard: got stall=%b busy=%b, want 1 1", dec_stall, busy);
    end
    tick();
    // Cycle N+2: held ALU request goes straight through.
    #1;
    n_cmp++;
    if (wreg !== 1'b1 || rd_addr !== 5'd9 || rd_data !== 32'hCC || alu_ready !== 1'b1 ||
        dec_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_n2: got wreg=%b addr=%0d data=%h rdy=%b stall=%b, want 1 9 000000cc 1 0",
               wreg, rd_addr, rd_data, alu_ready, dec_stall);
    end
    tick();
    idle();
  endtask

  task automatic test_load_hazard();
    // Cycle N: issue; no stall yet.
    idle();
    ld_issue = 1; ld_issue_rd = 3; dec_rs1_addr = 3;
    #1;
    n_cmp++;
    if (dec_stall !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_issue_cycle: got stall=%b busy=%b, want 0 0", dec_stall, busy);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      idle();
      dec_rs1_addr = 3;
      #1;
      n_cmp++;
      if (dec_stall !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL ld_pending[%0d]: got stall=%b busy=%b, want 1 1", i, dec_stall, busy);
      end
      tick();
    end
    // Return cycle: stall still asserted, data written.
    idle();
    dec_rs1_addr = 3;
    lsu_valid = 1; lsu_rd_addr = 3; lsu_rd_data = 32'h55;
    #1;
    n_cmp++;
    if (dec_stall !== 1'b1 || wreg !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'h55) begin
      n_fail++;
      $display("FAIL ld_return: got stall=%b wreg=%b addr=%0d data=%h, want 1 1 3 00000055",
               dec_stall, wreg, rd_addr, rd_data);
    end
    tick();
    idle();
    dec_rs1_addr = 3;
    #1;
    n_cmp++;
    if (dec_stall !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_cleared: got stall=%b busy=%b, want 0 0", dec_stall, busy);
    end
    tick();
    idle();
  endtask

  task automatic test_set_clear_race();
    idle();
    ld_issue = 1; ld_issue_rd = 4;
    tick();
    idle();
    dec_rs2_addr = 4;
    ld_issue = 1; ld_issue_rd = 4;
    lsu_valid = 1; lsu_rd_addr = 4; lsu_rd_data = 32'h44;
    #1;
    n_cmp++;
    if (dec_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL race_same_cycle: got stall=%b, want 1", dec_stall);
    end
    tick();
    idle();
    dec_rs2_addr = 4;
    #1;
    n_cmp++;
    if (dec_stall !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL race_set_wins: got stall=%b busy=%b, want 1 1", dec_stall, busy);
    end
    tick();
    idle();
    lsu_valid = 1; lsu_rd_addr = 4; lsu_rd_data = 32'h45;
    tick();
    idle();
    dec_rs2_addr = 4;
    #1;
    n_cmp++;
    if (dec_stall !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL race_drained: got stall=%b busy=%b, want 0 0", dec_stall, busy);
    end
    tick();
    idle();
  endtask

  task automatic test_x0();
    idle();
    alu_valid = 1; alu_rd_addr = 0; alu_rd_data = 32'hFF;
    ld_issue = 1; ld_issue_rd = 0;
    #1;
    n_cmp++;
    if (wreg !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_alu: got wreg=%b addr=%0d data=%h, want 0 0 00000000", wreg, rd_addr, rd_data);
    end
    tick();
    idle();
    lsu_valid = 1; lsu_rd_addr = 0; lsu_rd_data = 32'h77;
    #1;
    n_cmp++;
    if (wreg !== 1'b0 || busy !== 1'b0 || dec_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_load: got wreg=%b busy=%b stall=%b, want 0 0 0", wreg, busy, dec_stall);
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid_collision();
    idle();
    ld_issue = 1; ld_issue_rd = 12;
    tick();
    idle();
    lsu_valid = 1; lsu_rd_addr = 10; lsu_rd_data = 32'h10;
    alu_valid = 1; alu_rd_addr = 11; alu_rd_data = 32'h11;
    tick();
    idle();
    #1;
    n_cmp++;
    if (alu_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_skid: got rdy=%b busy=%b, want 0 1", alu_ready, busy);
    end
    rstn = 0;
    #1;
    n_cmp++;
    if (wreg !== 1'b0 || alu_ready !== 1'b1 || busy !== 1'b0 || dec_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got wreg=%b rdy=%b busy=%b stall=%b, want 0 1 0 0",
               wreg, alu_ready, busy, dec_stall);
    end
    tick();
    @(negedge clk);
    rstn = 1;
    tick();
    dec_rs1_addr = 12;
    dec_rd_addr  = 11;
    #1;
    n_cmp++;
    if (wreg !== 1'b0 || alu_ready !== 1'b1 || busy !== 1'b0 || dec_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL after_release: got wreg=%b rdy=%b busy=%b stall=%b, want 0 1 0 0",
               wreg, alu_ready, busy, dec_stall);
    end
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_collision();
    test_load_hazard();
    test_set_clear_race();
    test_x0();
    test_reset_mid_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
